key_pio_in: RTL and testbench
=============================

Name: key_pio_in

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the single-bit output PIO used for OLED control.
- Samples WIDTH asynchronous board inputs (push-keys, OLED busy/status lines) and synchronises them.
- Captures edges into a sticky register and raises a maskable level interrupt to the Nios II CPU.
- Zero-wait-state register file on the s1 slave, same bus shape as the output PIOs in the SOPC system.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
- DEB_CYCLES, 50000, stable cycles required before a debounced input updates (used only with KEY_PIO_DEBOUNCE_EN).
- DEB_CNT_W, 16, debounce counter width; must satisfy 2^DEB_CNT_W > DEB_CYCLES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset; all flops clear when it asserts.
- address  in  2  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  combinational read data, zero wait states.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: sync1, sync2, data_q, d1, irq_mask, edge_capture and warm-up counter all 0.
  - irq = 0 and readdata = 0 while reset_n is low, provided address is 0 or 1.
- Synchroniser: sync1 <= in_port; sync2 <= sync1.
  - Without debounce, data_q = sync2.
- Previous-value register: d1 <= data_q every cycle.
- Edge detect, per bit:
  - rising: data_q & ~d1
  - falling: ~data_q & d1
  - any: data_q ^ d1
- Warm-up: a 2-bit counter increments from 0 after reset and saturates at 3.
  - Edge detect is forced to 0 while the counter is below 3, so inputs idling high after reset produce no spurious capture.
- Write decode: a write occurs when chipselect && !write_n. Writes to address 0 and 1 are ignored.
- edge_capture[i] is sticky. It sets on a detected edge.
  - Any write to address 3 clears all bits.
  - If an edge and a clear occur in the same cycle, set wins and the bit reads 1 afterwards.
- irq_mask[WIDTH-1:0] loads writedata[WIDTH-1:0] on a write to address 2.
- irq = |(edge_capture & irq_mask), driven combinationally from registers with no extra delay.
- Read map (combinational, unused upper bits 0):
  - address 0: data_q
  - address 1: 0
  - address 2: irq_mask
  - address 3: edge_capture
  - chipselect is not required for reads.
- Latency without debounce:
  - A change on in_port before clk edge k is visible at address 0 after edge k+1.
  - edge_capture and irq assert after edge k+2.
- Reset asserted mid-operation clears captures and mask immediately; warm-up restarts.

Optional Feature:
- Macro KEY_PIO_DEBOUNCE_EN.
- Defined: each bit passes sync2 through a debounce filter, and data_q follows the filter output.
  - The filter holds a per-bit counter.
  - When sync2 differs from the current stable value, the counter increments.
  - When the counter reaches DEB_CYCLES-1 with sync2 still different, the stable value takes sync2 and the counter resets to 0.
  - Any cycle where sync2 equals the stable value resets the counter to 0.
  - This adds DEB_CYCLES cycles of latency; glitches shorter than DEB_CYCLES never reach data_q.
  - Stable value and counter reset to 0.
- Undefined: no counters exist; data_q = sync2; DEB_CYCLES and DEB_CNT_W are unused.

Decomposition:
- Package key_pio_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - edge-type constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, key_pio_debounce: single-bit filter with ports clk, reset_n, din, dout and parameters DEB_CYCLES, DEB_CNT_W.
  - Instantiated WIDTH times in a generate loop, only under KEY_PIO_DEBOUNCE_EN.

Test Plan:
- Reset with in_port=4'hF held: after 10 cycles, edge_capture=0, irq=0, and a read of address 0 returns 32'h0000000F.
- EDGE_TYPE=0, mask=4'h1 written to address 2, in_port bit0 0->1 before edge k: edge_capture=4'h1 and irq=1 after edge k+2; address 3 reads 32'h1.
- Same setup, any write to address 3 (writedata=0) in the same cycle bit0 makes a new rise: edge_capture stays 4'h1. A clear-only write on the next cycle gives edge_capture=0 and irq=0.
- Mask=0 with bit2 falling under EDGE_TYPE=1: edge_capture=4'h4 and irq=0. Then write mask=4'h4: irq=1 on the next cycle.
- reset_n pulsed low mid-capture (edge_capture=4'hA, mask=4'hF): irq=0 and all reads return 0 immediately; no capture within 3 cycles of release.
- KEY_PIO_DEBOUNCE_EN, DEB_CYCLES=8:
  - a 5-cycle high pulse on bit0 leaves data_q=0 and no capture;
  - a level held high for 20 cycles sets data_q[0]=1 exactly 8 cycles after sync2 rises.

Source files
------------

// File: rtl/key_pio_pkg.sv
// key_pio_pkg: shared constants for the key_pio_in input PIO.
//   - Register word addresses on the s1 slave.
//   - Capture edge selectors for the EDGE_TYPE parameter.
package key_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/key_pio_debounce.sv
// key_pio_debounce: single-bit debounce filter for key_pio_in.
// Built only when KEY_PIO_DEBOUNCE_EN is defined; otherwise this file is empty.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   din      in   synchronised input bit
//   dout     out  debounced (stable) value
// dout takes din only after din has differed from it for DEB_CYCLES
// consecutive cycles; any cycle where they match restarts the count.
`ifdef KEY_PIO_DEBOUNCE_EN
module key_pio_debounce #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned DEB_CNT_W  = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam logic [DEB_CNT_W-1:0] CntMax = DEB_CNT_W'(DEB_CYCLES - 1);

    logic                 stable_q, stable_d;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (din != stable_q) begin
            if (cnt_q == CntMax) begin
                stable_d = din;
            end else begin
                cnt_d = cnt_q + DEB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule
`endif

// File: rtl/key_pio_in.sv
// key_pio_in: Avalon-MM slave input PIO with sticky edge capture and a
// maskable level interrupt.
// Optional feature macro: KEY_PIO_DEBOUNCE_EN (per-bit debounce filter).
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   register word select (0 data, 1 reserved, 2 irq mask, 3 edge capture)
//   chipselect  in   slave select (writes only)
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   in_port     in   asynchronous external inputs
//   readdata    out  combinational read data, zero wait states
//   irq         out  level interrupt, active high
module key_pio_in
    import key_pio_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned EDGE_TYPE  = 0,
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned DEB_CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE > 2 ||
        (64'd1 << DEB_CNT_W) <= 64'(DEB_CYCLES)) begin : g_param_err
        $error("key_pio_in: illegal parameter combination");
    end

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] d1_q;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] edge_raw, edge_det;
    logic [1:0]       warm_q, warm_d;
    logic             wr_en;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata are meaningful.
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    logic [WIDTH-1:0] deb_out;

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        key_pio_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .DEB_CNT_W  (DEB_CNT_W)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (sync2_q[i]),
            .dout    (deb_out[i])
        );
    end

    assign data_q = deb_out;
`else
    assign data_q = sync2_q;
`endif

    assign wr_en = chipselect && !write_n;

    always_comb begin
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_raw = ~data_q & d1_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_raw = data_q ^ d1_q;
        end else begin
            edge_raw = data_q & ~d1_q;
        end
        // Suppress the artificial 0->input transition seen while the
        // synchroniser fills after reset.
        edge_det = (warm_q == 2'd3) ? edge_raw : '0;
    end

    always_comb begin
        warm_d         = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        irq_mask_d     = irq_mask_q;
        edge_capture_d = edge_capture_q;
        if (wr_en && address == ADDR_IRQMASK) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGECAP) begin
            edge_capture_d = '0;
        end
        // Set after clear so a coincident edge is not lost.
        edge_capture_d = edge_capture_d | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1_q           <= '0;
            warm_q         <= 2'd0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
        end else begin
            d1_q           <= data_q;
            warm_q         <= warm_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
        end
    end

    assign irq = |(edge_capture_q & irq_mask_q);

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = data_q;
            ADDR_RSVD:    readdata            = '0;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture_q;
            default:      readdata            = '0;
        endcase
    end

endmodule

// File: tb/tb_key_pio_in.sv
module tb_key_pio_in;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  in_r = 4'h0;
    logic [3:0]  in_f = 4'h0;
    logic [31:0] rd_r, rd_f;
    logic        irq_r, irq_f;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_pio_in #(
        .WIDTH      (4),
        .EDGE_TYPE  (0),
        .DEB_CYCLES (8),
        .DEB_CNT_W  (4)
    ) dut_r (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_r),
        .readdata   (rd_r),
        .irq        (irq_r)
    );

    key_pio_in #(
        .WIDTH      (4),
        .EDGE_TYPE  (1),
        .DEB_CYCLES (8),
        .DEB_CNT_W  (4)
    ) dut_f (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_f),
        .readdata   (rd_f),
        .irq        (irq_f)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic set_addr(input logic [1:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset;
        in_r = 4'hF;
        in_f = 4'hF;
        reset_n = 1'b0;
        tick(2);
        set_addr(2'd0);
        checks++;
        if (rd_r !== 32'd0) begin
            failures++;
            $display("FAIL reset_low_data: got %h want %h", rd_r, 32'd0);
        end
        set_addr(2'd1);
        checks++;
        if (rd_r !== 32'd0 || irq_r !== 1'b0) begin
            failures++;
            $display("FAIL reset_low_rsvd_irq: got %h/%b want 0/0", rd_r, irq_r);
        end
        tick(1);
        reset_n = 1'b1;
        tick(10);
        set_addr(2'd3);
        checks++;
        if (rd_r !== 32'd0 || irq_r !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_spurious_cap: got %h/%b want 0/0", rd_r, irq_r);
        end
        set_addr(2'd0);
        checks++;
        if (rd_r !== 32'h0000000F) begin
            failures++;
            $display("FAIL reset_data_f: got %h want %h", rd_r, 32'h0000000F);
        end
        checks++;
        if (rd_f !== 32'h0000000F) begin
            failures++;
            $display("FAIL reset_data_f_fall: got %h want %h", rd_f, 32'h0000000F);
        end
    endtask

    task automatic test_rise_capture;
        in_r = 4'hE;
        tick(4);
        bus_write(2'd3, 32'd0);
        bus_write(2'd2, 32'h1);
        in_r = 4'hF;
        tick(1);
        set_addr(2'd0);
        checks++;
        if (rd_r !== 32'hE) begin
            failures++;
            $display("FAIL rise_data_k: got %h want %h", rd_r, 32'hE);
        end
        tick(1);
        set_addr(2'd0);
        checks++;
        if (rd_r !== 32'hF || irq_r !== 1'b0) begin
            failures++;
            $display("FAIL rise_data_k1: got %h/%b want %h/0", rd_r, irq_r, 32'hF);
        end
        set_addr(2'd3);
        checks++;
        if (rd_r !== 32'h0) begin
            failures++;
            $display("FAIL rise_cap_k1: got %h want %h", rd_r, 32'h0);
        end
        tick(1);
        set_addr(2'd3);
        checks++;
        if (rd_r !== 32'h1 || irq_r !== 1'b1) begin
            failures++;
            $display("FAIL rise_cap_k2: got %h/%b want %h/1", rd_r, irq_r, 32'h1);
        end
    endtask

    task automatic test_clear_collision;
        in_r = 4'hE;
        tick(4);
        in_r = 4'hF;
        tick(2);
        // Clear lands on the same edge that captures the new rise.
        bus_write(2'd3, 32'd0);
        set_addr(2'd3);
        checks++;
        if (rd_r !== 32'h1 || irq_r !== 1'b1) begin
            failures++;
            $display("FAIL collision_set_wins: got %h/%b want %h/1", rd_r, irq_r, 32'h1);
        end
        bus_write(2'd3, 32'd0);
        set_addr(2'd3);
        checks++;
        if (rd_r !== 32'h0 || irq_r !== 1'b0) begin
            failures++;
            $display("FAIL clear_only: got %h/%b want 0/0", rd_r, irq_r);
        end
    endtask

    task automatic test_fall_mask;
        bus_write(2'd2, 32'd0);
        bus_write(2'd3, 32'd0);
        in_f = 4'hB;
        tick(3);
        set_addr(2'd3);
        checks++;
        if (rd_f !== 32'h4 || irq_f !== 1'b0) begin
            failures++;
            $display("FAIL fall_masked: got %h/%b want %h/0", rd_f, irq_f, 32'h4);
        end
        bus_write(2'd2, 32'h4);
        checks++;
        if (irq_f !== 1'b1) begin
            failures++;
            $display("FAIL fall_unmask_irq: got %b want 1", irq_f);
        end
        set_addr(2'd2);
        checks++;
        if (rd_f !== 32'h4) begin
            failures++;
            $display("FAIL mask_readback: got %h want %h", rd_f, 32'h4);
        end
    endtask

    task automatic test_ignored_writes;
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        set_addr(2'd0);
        checks++;
        if (rd_f !== 32'hB) begin
            failures++;
            $display("FAIL write_addr0_ignored: got %h want %h", rd_f, 32'hB);
        end
        set_addr(2'd1);
        checks++;
        if (rd_f !== 32'h0) begin
            failures++;
            $display("FAIL rsvd_reads_zero: got %h want %h", rd_f, 32'h0);
        end
        // Write strobe without chipselect must not load the mask.
        address   = 2'd2;
        writedata = 32'h0;
        write_n   = 1'b0;
        tick(1);
        write_n   = 1'b1;
        set_addr(2'd2);
        checks++;
        if (rd_f !== 32'h4) begin
            failures++;
            $display("FAIL no_cs_write: got %h want %h", rd_f, 32'h4);
        end
    endtask

    task automatic test_reset_mid;
        in_r = 4'h5;
        tick(4);
        bus_write(2'd3, 32'd0);
        in_r = 4'hF;
        tick(3);
        bus_write(2'd2, 32'hF);
        set_addr(2'd3);
        checks++;
        if (rd_r !== 32'hA || irq_r !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_cap: got %h/%b want %h/1", rd_r, irq_r, 32'hA);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (irq_r !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_irq: got %b want 0", irq_r);
        end
        for (int a = 0; a < 4; a++) begin
            set_addr(2'(a));
            checks++;
            if (rd_r !== 32'h0) begin
                failures++;
                $display("FAIL mid_reset_read%0d: got %h want %h", a, rd_r, 32'h0);
            end
        end
        tick(1);
        reset_n = 1'b1;
        tick(3);
        set_addr(2'd3);
        checks++;
        if (rd_r !== 32'h0 || irq_r !== 1'b0) begin
            failures++;
            $display("FAIL mid_warmup_no_cap: got %h/%b want 0/0", rd_r, irq_r);
        end
        tick(3);
        set_addr(2'd3);
        checks++;
        if (rd_r !== 32'h0) begin
            failures++;
            $display("FAIL mid_late_no_cap: got %h want %h", rd_r, 32'h0);
        end
    endtask

    task automatic test_debounce;
        in_r = 4'h0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        in_r = 4'h1;
        tick(5);
        in_r = 4'h0;
        tick(20);
        set_addr(2'd0);
        checks++;
        if (rd_r !== 32'h0) begin
            failures++;
            $display("FAIL deb_glitch_data: got %h want %h", rd_r, 32'h0);
        end
        set_addr(2'd3);
        checks++;
        if (rd_r !== 32'h0) begin
            failures++;
            $display("FAIL deb_glitch_cap: got %h want %h", rd_r, 32'h0);
        end
        // sync2 rises on the 2nd edge; stable value follows 8 edges later.
        in_r = 4'h1;
        tick(9);
        set_addr(2'd0);
        checks++;
        if (rd_r !== 32'h0) begin
            failures++;
            $display("FAIL deb_early: got %h want %h", rd_r, 32'h0);
        end
        tick(1);
        set_addr(2'd0);
        checks++;
        if (rd_r !== 32'h1) begin
            failures++;
            $display("FAIL deb_on_time: got %h want %h", rd_r, 32'h1);
        end
        tick(10);
    endtask

    initial begin
`ifdef KEY_PIO_DEBOUNCE_EN
        test_debounce();
`else
        test_reset();
        test_rise_capture();
        test_clear_collision();
        test_fall_mask();
        test_ignored_writes();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
